new_task_stream_arbiter: RTL and testbench

// - Merges the per-accelerator new-task request streams into one AXI-Stream that feeds the cutoff manager's inStream.
// - Arbitrates round-robin between accelerators, one whole packet at a time, so a packet is never interleaved with another.
// - Tags every output beat with the source accelerator index (tid) and forwards tdest unchanged.
// - The output passes through a 2-entry skid buffer, so a granted source streams at 1 beat/cycle.

---
 rtl/new_task_stream_arbiter.sv | 162 ++++++++++++++++
 tb/tb_new_task_stream_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/new_task_stream_arbiter.sv
// Merges per-accelerator new-task AXI-Streams into one stream, round-robin, one whole packet per grant.
// Latency: 1 cycle arbitration gap per packet; an accepted beat is visible on out_* the next cycle.
// Backpressure: 2-entry skid buffer; acc_tready[grant] drops only when both entries are occupied.
//
// Ports: clk/rst (sync, active-high); acc_t{valid,ready,data,last,dest} per port, packed by index;
//        out_t{valid,ready,data,last,id,dest} merged stream, out_tid = source port index.
// Optional: define NEW_TASK_ARB_PKT_CNT_EN to add pkt_count[31:0] (packets leaving on out_*, wraps).
module new_task_stream_arbiter #(
    parameter  int MAX_ACCS = 16,
    localparam int ACC_BITS = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MAX_ACCS-1:0]    acc_tvalid,
    output logic [MAX_ACCS-1:0]    acc_tready,
    input  logic [64*MAX_ACCS-1:0] acc_tdata,
    input  logic [MAX_ACCS-1:0]    acc_tlast,
    input  logic [5*MAX_ACCS-1:0]  acc_tdest,
    output logic                   out_tvalid,
    input  logic                   out_tready,
    output logic [63:0]            out_tdata,
    output logic                   out_tlast,
    output logic [ACC_BITS-1:0]    out_tid,
    output logic [4:0]             out_tdest
`ifdef NEW_TASK_ARB_PKT_CNT_EN
    ,
    output logic [31:0]            pkt_count
`endif
);

    typedef enum logic {ARB, FWD} state_t;

    typedef struct packed {
        logic [63:0]         data;
        logic                last;
        logic [4:0]          dest;
        logic [ACC_BITS-1:0] tid;
    } beat_t;

    state_t              state;
    logic [ACC_BITS-1:0] grant;
    logic [ACC_BITS-1:0] last_grant;

    beat_t               buf_mem [2];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          count;

    // Round-robin pick: first valid port after last_grant, wrapping.
    logic                any_vld;
    logic [ACC_BITS-1:0] next_grant;
    int                  scan_idx;
    logic [ACC_BITS-1:0] scan_sel;

    always_comb begin
        any_vld    = 1'b0;
        next_grant = '0;
        scan_idx   = 0;
        scan_sel   = '0;
        for (int i = 1; i <= MAX_ACCS; i++) begin
            scan_idx = (int'(last_grant) + i) % MAX_ACCS;
            scan_sel = ACC_BITS'(scan_idx);
            if (!any_vld && acc_tvalid[scan_sel]) begin
                any_vld    = 1'b1;
                next_grant = scan_sel;
            end
        end
    end

    // Granted-port fields; other ports' inputs never reach the datapath.
    logic        sel_vld;
    logic [63:0] sel_data;
    logic        sel_last;
    logic [4:0]  sel_dest;

    assign sel_vld  = acc_tvalid[grant];
    assign sel_data = acc_tdata[64*grant +: 64];
    assign sel_last = acc_tlast[grant];
    assign sel_dest = acc_tdest[5*grant +: 5];

    logic buf_full;
    logic push;
    logic pop;

    assign buf_full = (count == 2'd2);
    assign push     = (state == FWD) && sel_vld && !buf_full;
    assign pop      = (count != 2'd0) && out_tready;

    // Ready is a decode of registered state only, so it never depends on
    // out_tready combinationally.
    always_comb begin
        acc_tready = '0;
        if (state == FWD && !buf_full) begin
            acc_tready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            grant      <= '0;
            last_grant <= ACC_BITS'(MAX_ACCS - 1);
        end else begin
            case (state)
                ARB: begin
                    if (any_vld) begin
                        grant <= next_grant;
                        state <= FWD;
                    end
                end
                FWD: begin
                    // Grant is held until tlast, however long the source stalls.
                    if (push && sel_last) begin
                        last_grant <= grant;
                        state      <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr] <= '{data: sel_data, last: sel_last, dest: sel_dest, tid: grant};
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_tvalid = (count != 2'd0);
    assign out_tdata  = buf_mem[rd_ptr].data;
    assign out_tlast  = buf_mem[rd_ptr].last;
    assign out_tid    = buf_mem[rd_ptr].tid;
    assign out_tdest  = buf_mem[rd_ptr].dest;

`ifdef NEW_TASK_ARB_PKT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (out_tvalid && out_tready && out_tlast) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_new_task_stream_arbiter.sv
module tb_new_task_stream_arbiter;

    localparam int N = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    acc_tvalid;
    logic [N-1:0]    acc_tready;
    logic [64*N-1:0] acc_tdata;
    logic [N-1:0]    acc_tlast;
    logic [5*N-1:0]  acc_tdest;
    logic            out_tvalid;
    logic            out_tready;
    logic [63:0]     out_tdata;
    logic            out_tlast;
    logic [3:0]      out_tid;
    logic [4:0]      out_tdest;
`ifdef NEW_TASK_ARB_PKT_CNT_EN
    logic [31:0]     pkt_count;
`endif

    new_task_stream_arbiter #(.MAX_ACCS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .acc_tvalid (acc_tvalid),
        .acc_tready (acc_tready),
        .acc_tdata  (acc_tdata),
        .acc_tlast  (acc_tlast),
        .acc_tdest  (acc_tdest),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .out_tid    (out_tid),
        .out_tdest  (out_tdest)
`ifdef NEW_TASK_ARB_PKT_CNT_EN
        ,
        .pkt_count  (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- packet-level reference model ----------------
    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [4:0]  dest;
    } sbeat_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [4:0]  dest;
        int          tid;
    } ebeat_t;

    sbeat_t src_q [N][$];
    ebeat_t exp_q [$];
    int     pkt_tids [$];
    int     m_last  = N - 1;
    int     pkt_seq = 0;

    task automatic add_pkt(input int p, input int nbeats);
        sbeat_t b;
        b.dest = 5'($urandom);
        for (int i = 0; i < nbeats; i++) begin
            b.data = (64'(p) << 56) | (64'(pkt_seq) << 16) | 64'(i);
            b.last = (i == nbeats - 1);
            src_q[p].push_back(b);
        end
        pkt_seq++;
    endtask

    // Whole packets leave in round-robin order over ports that still hold packets.
    task automatic build_expected();
        sbeat_t tmp [N][$];
        bit     found;
        sbeat_t b;
        ebeat_t e;
        for (int p = 0; p < N; p++) tmp[p] = src_q[p];
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int i = 1; i <= N && !found; i++) begin
                int p;
                p = (m_last + i) % N;
                if (tmp[p].size() > 0) begin
                    found = 1'b1;
                    m_last = p;
                    do begin
                        b = tmp[p].pop_front();
                        e.data = b.data; e.last = b.last; e.dest = b.dest; e.tid = p;
                        exp_q.push_back(e);
                    end while (!b.last);
                end
            end
        end
    endtask

    // Drives every queued packet through the DUT and checks the merged stream.
    task automatic run(input string tag, input bit gaps, input bit rnd_ready);
        bit [N-1:0]  midpkt = '0;
        bit          out_in_pkt = 1'b0;
        int          cycles = 0;
        int          multi_rdy = 0;
        int          unstable = 0;
        bit          prev_stall = 1'b0;
        logic [73:0] prev_out = '0;
        ebeat_t      e;
        build_expected();
        pkt_tids.delete();
        while (exp_q.size() > 0 && cycles < 5000) begin
            acc_tvalid = '0;
            for (int p = 0; p < N; p++) begin
                acc_tdata[p*64 +: 64] = {$urandom, $urandom};
                acc_tlast[p]          = 1'($urandom);
                acc_tdest[p*5 +: 5]   = 5'($urandom);
                if (src_q[p].size() > 0 && !(gaps && midpkt[p] && ($urandom % 4 == 0))) begin
                    acc_tvalid[p]         = 1'b1;
                    acc_tdata[p*64 +: 64] = src_q[p][0].data;
                    acc_tlast[p]          = src_q[p][0].last;
                    acc_tdest[p*5 +: 5]   = src_q[p][0].dest;
                end
            end
            out_tready = rnd_ready ? ($urandom % 3 != 0) : 1'b1;
            #1;
            if ($countones(acc_tready) > 1) multi_rdy++;
            if (prev_stall && out_tvalid &&
                {out_tdata, out_tlast, out_tdest, out_tid} != prev_out) unstable++;
            for (int p = 0; p < N; p++) begin
                if (acc_tvalid[p] && acc_tready[p]) begin
                    midpkt[p] = !src_q[p][0].last;
                    void'(src_q[p].pop_front());
                end
            end
            if (out_tvalid && out_tready) begin
                e = exp_q.pop_front();
                chk({tag, "_beat"}, {out_tdata, out_tlast, out_tdest, out_tid},
                    {e.data, e.last, e.dest, 4'(e.tid)});
                if (!out_in_pkt) pkt_tids.push_back(int'(out_tid));
                out_in_pkt = !out_tlast;
            end
            prev_stall = out_tvalid && !out_tready;
            prev_out   = {out_tdata, out_tlast, out_tdest, out_tid};
            tick();
            cycles++;
        end
        chk({tag, "_beats_left"}, 80'(exp_q.size()), 80'd0);
        chk({tag, "_ready_onehot"}, 80'(multi_rdy), 80'd0);
        chk({tag, "_hold_stable"}, 80'(unstable), 80'd0);
        exp_q.delete();
        for (int p = 0; p < N; p++) src_q[p].delete();
        acc_tvalid = '0;
        out_tready = 1'b1;
        chk({tag, "_drained"}, 80'(out_tvalid), 80'd0);
    endtask

    task automatic chk_tids(input string tag, input int exp_ids [$]);
        chk({tag, "_npkts"}, 80'(pkt_tids.size()), 80'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size() && i < pkt_tids.size(); i++)
            chk({tag, "_grant_order"}, 80'(pkt_tids[i]), 80'(exp_ids[i]));
    endtask

    // ---------------- table-driven cycle vectors ----------------
    typedef struct {
        int          port;
        bit          vld;
        logic [63:0] data;
        bit          last;
        logic [4:0]  dest;
        bit          otr;
        bit          e_vld;
        logic [63:0] e_data;
        bit          e_last;
        int          e_tid;
        logic [4:0]  e_dest;
        bit          e_rdy;
    } vec_t;

    vec_t tbl [$];

    task automatic apply_table(input string tag);
        foreach (tbl[k]) begin
            acc_tvalid = '0;
            acc_tdata  = '0;
            acc_tlast  = '0;
            acc_tdest  = '0;
            acc_tvalid[tbl[k].port]          = tbl[k].vld;
            acc_tdata[tbl[k].port*64 +: 64]  = tbl[k].data;
            acc_tlast[tbl[k].port]           = tbl[k].last;
            acc_tdest[tbl[k].port*5 +: 5]    = tbl[k].dest;
            out_tready = tbl[k].otr;
            #1;
            chk({tag, "_out_tvalid"}, 80'(out_tvalid), 80'(tbl[k].e_vld));
            chk({tag, "_acc_tready"}, 80'(acc_tready),
                tbl[k].e_rdy ? (80'd1 << tbl[k].port) : 80'd0);
            if (tbl[k].e_vld)
                chk({tag, "_out_beat"}, {out_tdata, out_tlast, out_tdest, out_tid},
                    {tbl[k].e_data, tbl[k].e_last, tbl[k].e_dest, 4'(tbl[k].e_tid)});
            tick();
        end
        tbl.delete();
        acc_tvalid = '0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        acc_tvalid = '0;
        acc_tdata  = '0;
        acc_tlast  = '0;
        acc_tdest  = '0;
        out_tready = 1'b1;
        repeat (3) tick();
        rst    = 1'b0;
        m_last = N - 1;
    endtask

    initial begin
        int ids [$];

        // Reset values
        do_reset();
        chk("rst_out_tvalid", 80'(out_tvalid), 80'd0);
        chk("rst_acc_tready", 80'(acc_tready), 80'd0);
        chk("rst_out_fields", {out_tdata, out_tlast, out_tdest, out_tid}, 80'd0);
`ifdef NEW_TASK_ARB_PKT_CNT_EN
        chk("rst_pkt_count", 80'(pkt_count), 80'd0);
`endif

        // Port 3, three beats, tdest 5: first out_tvalid two cycles after valid rises.
        //             port vld data    lst dst otr | e_vld e_data  e_lst tid dst rdy
        tbl.push_back('{3, 1, 64'h11, 0, 5, 1,  0, 64'h0,  0, 0, 0, 0});
        tbl.push_back('{3, 1, 64'h11, 0, 5, 1,  0, 64'h0,  0, 0, 0, 1});
        tbl.push_back('{3, 1, 64'h22, 0, 5, 1,  1, 64'h11, 0, 3, 5, 1});
        tbl.push_back('{3, 1, 64'h33, 1, 5, 1,  1, 64'h22, 0, 3, 5, 1});
        tbl.push_back('{3, 0, 64'h0,  0, 5, 1,  1, 64'h33, 1, 3, 5, 0});
        tbl.push_back('{3, 0, 64'h0,  0, 5, 1,  0, 64'h0,  0, 0, 0, 0});
        apply_table("p3");

        // Port 6, six beats, out_tready low for 4 cycles mid-packet.
        do_reset();
        tbl.push_back('{6, 1, 64'hA1, 0, 9, 1,  0, 64'h0,  0, 0, 0, 0});
        tbl.push_back('{6, 1, 64'hA1, 0, 9, 1,  0, 64'h0,  0, 0, 0, 1});
        tbl.push_back('{6, 1, 64'hA2, 0, 9, 0,  1, 64'hA1, 0, 6, 9, 1});
        tbl.push_back('{6, 1, 64'hA3, 0, 9, 0,  1, 64'hA1, 0, 6, 9, 0});
        tbl.push_back('{6, 1, 64'hA3, 0, 9, 0,  1, 64'hA1, 0, 6, 9, 0});
        tbl.push_back('{6, 1, 64'hA3, 0, 9, 0,  1, 64'hA1, 0, 6, 9, 0});
        tbl.push_back('{6, 1, 64'hA3, 0, 9, 1,  1, 64'hA1, 0, 6, 9, 0});
        tbl.push_back('{6, 1, 64'hA3, 0, 9, 1,  1, 64'hA2, 0, 6, 9, 1});
        tbl.push_back('{6, 1, 64'hA4, 0, 9, 1,  1, 64'hA3, 0, 6, 9, 1});
        tbl.push_back('{6, 1, 64'hA5, 0, 9, 1,  1, 64'hA4, 0, 6, 9, 1});
        tbl.push_back('{6, 1, 64'hA6, 1, 9, 1,  1, 64'hA5, 0, 6, 9, 1});
        tbl.push_back('{6, 0, 64'h0,  0, 9, 1,  1, 64'hA6, 1, 6, 9, 0});
        tbl.push_back('{6, 0, 64'h0,  0, 9, 1,  0, 64'h0,  0, 0, 0, 0});
        apply_table("stall");

        // Ports 0 and 5 together after reset: no interleave.
        do_reset();
        add_pkt(0, 2);
        add_pkt(5, 2);
        run("p0p5", 1'b0, 1'b0);
        ids = '{0, 5};
        chk_tids("p0p5", ids);

        // Port 2 back-to-back while port 1 pends: 1 must come between 2's packets.
        add_pkt(1, 1);
        run("p1", 1'b0, 1'b0);
        add_pkt(1, 3);
        add_pkt(2, 2);
        add_pkt(2, 2);
        run("wrap", 1'b0, 1'b0);
        ids = '{2, 1, 2};
        chk_tids("wrap", ids);

        // Fairness: all ports busy.
        do_reset();
        for (int p = 0; p < N; p++) add_pkt(p, 1 + (p % 3));
        add_pkt(0, 2);
        run("fair", 1'b0, 1'b0);
        ids.delete();
        for (int p = 0; p < N; p++) ids.push_back(p);
        ids.push_back(0);
        chk_tids("fair", ids);

        // Randomized traffic: source gaps mid-packet and random backpressure.
        for (int r = 0; r < 8; r++) begin
            int npk;
            npk = 1 + $urandom_range(0, 9);
            for (int k = 0; k < npk; k++) add_pkt($urandom_range(0, N - 1), $urandom_range(1, 5));
            run("rand", 1'b1, 1'b1);
        end

        // Reset mid-packet flushes the buffer.
        do_reset();
        acc_tvalid[4]       = 1'b1;
        acc_tdata[4*64 +: 64] = 64'hDEAD;
        acc_tlast[4]        = 1'b0;
        out_tready          = 1'b0;
        repeat (3) tick();
        chk("midrst_before", 80'(out_tvalid), 80'd1);
        rst = 1'b1;
        tick();
        chk("midrst_out_tvalid", 80'(out_tvalid), 80'd0);
        chk("midrst_acc_tready", 80'(acc_tready), 80'd0);
        chk("midrst_out_tdata", 80'(out_tdata), 80'd0);
        rst        = 1'b0;
        acc_tvalid = '0;
        out_tready = 1'b1;
        m_last     = N - 1;
        tick();
        add_pkt(9, 2);
        run("post_rst", 1'b0, 1'b0);

`ifdef NEW_TASK_ARB_PKT_CNT_EN
        force dut.pkt_count = 32'hFFFF_FFFF;
        tick();
        release dut.pkt_count;
        add_pkt(7, 2);
        run("cnt", 1'b0, 1'b0);
        chk("pkt_count_wrap", 80'(pkt_count), 80'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
